// File: rtl/cmov_select_stage.sv
// cmov_select_stage
// Registered conditional-move operand selector for the execute stage. Each
// accepted instruction either forwards its ALU operands or replaces them with
// a signed/unsigned min/max of rs/rt. Reduction ops (RMIN/RMAX) fold a running
// min/max across several instructions and emit one result on the last beat.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid / in_ready     input handshake
//   op                      op[3] signed compare; op[2:0] PASS/MIN/MAX/RMIN/RMAX
//   red_last                final beat of a reduction (RMIN/RMAX only)
//   rs_val, rt_val          compare operands
//   aluip1, aluip2          pass-through ALU operands
//   out_valid / out_ready   output handshake (one register stage)
//   aluip_fin1, aluip_fin2  final ALU operands / result
//   red_count               beats in the emitted reduction, 0 otherwise
//   red_discard             one-cycle pulse when a live accumulator is dropped
module cmov_select_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             red_last,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic [WIDTH-1:0] aluip1,
  input  logic [WIDTH-1:0] aluip2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluip_fin1,
  output logic [WIDTH-1:0] aluip_fin2,
  output logic [CNT_W-1:0] red_count,
  output logic             red_discard
);

  function automatic logic less_than(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b,
                                     input logic             sgn);
    if (sgn) less_than = ($signed(a) < $signed(b));
    else     less_than = (a < b);
  endfunction

  // Ties keep the first operand (rs for a fresh beat, acc for a fold).
  function automatic logic [WIDTH-1:0] sel_minmax(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic             is_max,
                                                  input logic             sgn);
    if (is_max) sel_minmax = less_than(a, b, sgn) ? b : a;
    else        sel_minmax = less_than(b, a, sgn) ? b : a;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] fin1_q, fin1_d;
  logic [WIDTH-1:0] fin2_q, fin2_d;
  logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
  logic             discard_q, discard_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             acc_active_q, acc_active_d;
  logic             acc_max_q, acc_max_d;
  logic             acc_sgn_q, acc_sgn_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;

  logic [2:0]       code;
  logic             sgn, is_mm, is_red, kind_max;
  logic             mismatch, restart, accept;
  logic [WIDTH-1:0] beat_val, red_val;
  logic [CNT_W-1:0] red_cnt;

  assign in_ready    = rst_n && (!out_valid_q || out_ready);
  assign accept      = in_valid && in_ready;
  assign out_valid   = out_valid_q;
  assign aluip_fin1  = fin1_q;
  assign aluip_fin2  = fin2_q;
  assign red_count   = cnt_out_q;
  assign red_discard = discard_q;

  always_comb begin
    code     = op[2:0];
    sgn      = op[3];
    is_mm    = (code == 3'd1) || (code == 3'd2);
    is_red   = (code == 3'd3) || (code == 3'd4);
    kind_max = (code == 3'd2) || (code == 3'd4);
    beat_val = sel_minmax(rs_val, rt_val, kind_max, sgn);
    // A reduction beat of a different kind throws away the live accumulator.
    mismatch = is_red && acc_active_q &&
               ((kind_max != acc_max_q) || (sgn != acc_sgn_q));
    restart  = !acc_active_q || mismatch;
    red_val  = restart ? beat_val : sel_minmax(acc_q, beat_val, acc_max_q, acc_sgn_q);
    red_cnt  = restart ? CNT_W'(1) : sat_inc(acc_cnt_q);
  end

  always_comb begin
    out_valid_d  = out_valid_q && !out_ready;
    fin1_d       = fin1_q;
    fin2_d       = fin2_q;
    cnt_out_d    = cnt_out_q;
    discard_d    = 1'b0;
    acc_d        = acc_q;
    acc_active_d = acc_active_q;
    acc_max_d    = acc_max_q;
    acc_sgn_d    = acc_sgn_q;
    acc_cnt_d    = acc_cnt_q;
    if (accept) begin
      if (is_red) begin
        discard_d = mismatch;
        if (red_last) begin
          out_valid_d  = 1'b1;
          fin1_d       = red_val;
          fin2_d       = '0;
          cnt_out_d    = red_cnt;
          acc_active_d = 1'b0;
          acc_d        = '0;
          acc_cnt_d    = '0;
        end else begin
          // Non-last beats only update the accumulator; no result is produced.
          acc_active_d = 1'b1;
          acc_d        = red_val;
          acc_cnt_d    = red_cnt;
          acc_max_d    = kind_max;
          acc_sgn_d    = sgn;
        end
      end else if (is_mm) begin
        out_valid_d = 1'b1;
        fin1_d      = beat_val;
        fin2_d      = '0;
        cnt_out_d   = '0;
      end else begin
        out_valid_d = 1'b1;
        fin1_d      = aluip1;
        fin2_d      = aluip2;
        cnt_out_d   = '0;
      end
    end
  end

  // Output / accumulator register stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      fin1_q       <= '0;
      fin2_q       <= '0;
      cnt_out_q    <= '0;
      discard_q    <= 1'b0;
      acc_q        <= '0;
      acc_active_q <= 1'b0;
      acc_max_q    <= 1'b0;
      acc_sgn_q    <= 1'b0;
      acc_cnt_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      fin1_q       <= fin1_d;
      fin2_q       <= fin2_d;
      cnt_out_q    <= cnt_out_d;
      discard_q    <= discard_d;
      acc_q        <= acc_d;
      acc_active_q <= acc_active_d;
      acc_max_q    <= acc_max_d;
      acc_sgn_q    <= acc_sgn_d;
      acc_cnt_q    <= acc_cnt_d;
    end
  end

endmodule

// File: tb/tb_cmov_select_stage.sv
module tb_cmov_select_stage;

  localparam logic [3:0] PASS = 4'd0, MIN = 4'd1, MAX = 4'd2, RMIN = 4'd3, RMAX = 4'd4, SGN = 4'd8;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, red_last, out_valid, out_ready, red_discard;
  logic [3:0]  op;
  logic [31:0] rs_val, rt_val, aluip1, aluip2, aluip_fin1, aluip_fin2;
  logic [7:0]  red_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] f1;
    logic [31:0] f2;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] red_b[$];
  bit          m_active, m_max, m_sgn;

  cmov_select_stage #(.WIDTH(32), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .red_last(red_last), .rs_val(rs_val), .rt_val(rt_val),
    .aluip1(aluip1), .aluip2(aluip2), .out_valid(out_valid), .out_ready(out_ready),
    .aluip_fin1(aluip_fin1), .aluip_fin2(aluip_fin2), .red_count(red_count),
    .red_discard(red_discard)
  );

  always #5 clk = ~clk;

  // Reference: min/max of two numbers under the chosen signedness.
  function automatic logic [31:0] pick(bit mx, bit sg, logic [31:0] a, logic [31:0] b);
    longint sa, sb;
    sa = sg ? longint'($signed(a)) : longint'(a);
    sb = sg ? longint'($signed(b)) : longint'(b);
    if (mx) return (sb > sa) ? b : a;
    else    return (sb < sa) ? b : a;
  endfunction

  // Reference: keep every beat value of the live reduction in a list and fold
  // the whole list when the last beat arrives.
  task automatic model_accept(input logic [3:0] o, input logic l, input logic [31:0] rs, rt, a1, a2,
                              output bit disc);
    exp_t e;
    bit mx;
    logic [31:0] b, r;
    disc = 0;
    case (o[2:0])
      3'd1, 3'd2: begin
        e.f1 = pick(o[2:0] == 3'd2, o[3], rs, rt); e.f2 = 0; e.cnt = 0; exp_q.push_back(e);
      end
      3'd3, 3'd4: begin
        mx = (o[2:0] == 3'd4);
        b = pick(mx, o[3], rs, rt);
        disc = m_active && ((mx != m_max) || (o[3] != m_sgn));
        if (!m_active || disc) begin
          red_b.delete(); m_max = mx; m_sgn = o[3];
        end
        red_b.push_back(b);
        m_active = 1;
        if (l) begin
          r = red_b[0];
          foreach (red_b[i]) r = pick(m_max, m_sgn, r, red_b[i]);
          e.f1 = r; e.f2 = 0; e.cnt = (red_b.size() > 255) ? 8'd255 : 8'(red_b.size());
          exp_q.push_back(e);
          red_b.delete();
          m_active = 0;
        end
      end
      default: begin
        e.f1 = a1; e.f2 = a2; e.cnt = 0; exp_q.push_back(e);
      end
    endcase
  endtask

  // Present one beat and wait (bounded) until it is accepted; returns at the
  // falling edge after the accepting rising edge.
  task automatic send(input logic [3:0] o, input logic l, input logic [31:0] rs, rt, a1, a2,
                      output int waited);
    op = o; red_last = l; rs_val = rs; rt_val = rt; aluip1 = a1; aluip2 = a2; in_valid = 1;
    #1;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk); #1; waited++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 0; red_last = 0;
  endtask

  task automatic test_reset;
    rst_n = 0; in_valid = 1; op = PASS; red_last = 0; out_ready = 1;
    rs_val = 0; rt_val = 0; aluip1 = 32'h55; aluip2 = 32'h66;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
    checks++;
    if ({out_valid, aluip_fin1, aluip_fin2, red_count, red_discard} !== 74'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b f1=%h f2=%h cnt=%0d d=%b required all 0",
               out_valid, aluip_fin1, aluip_fin2, red_count, red_discard);
    end
    in_valid = 0;
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_pass;
    int w;
    logic [72:0] snap;
    out_ready = 1;
    send(PASS, 0, 0, 0, 32'h11, 32'h22, w);
    snap = {out_valid, aluip_fin1, aluip_fin2, red_count};
    checks++;
    if (snap !== {1'b1, 32'h11, 32'h22, 8'd0}) begin
      errors++; $display("FAIL pass_basic: got %h required %h", snap, {1'b1, 32'h11, 32'h22, 8'd0});
    end
    out_ready = 0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0 || {out_valid, aluip_fin1, aluip_fin2, red_count} !== snap) begin
        errors++;
        $display("FAIL pass_hold[%0d]: in_ready=%b out=%h required in_ready=0 out=%h",
                 i, in_ready, {out_valid, aluip_fin1, aluip_fin2, red_count}, snap);
      end
      @(negedge clk); #1;
    end
    out_ready = 1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL pass_drain: out_valid=%b required 0", out_valid); end
    // Ops 5-7 behave as PASS and red_last is ignored for non-reduction ops.
    send(SGN | 4'd6, 1, 32'h1, 32'h2, 32'hDEAD, 32'hBEEF, w);
    checks++;
    if ({out_valid, aluip_fin1, aluip_fin2, red_count} !== {1'b1, 32'hDEAD, 32'hBEEF, 8'd0}) begin
      errors++; $display("FAIL pass_op6: got f1=%h f2=%h cnt=%0d required dead/beef/0", aluip_fin1, aluip_fin2, red_count);
    end
  endtask

  task automatic test_signedness;
    int w;
    logic [3:0]  ops[5] = '{MIN, MIN | SGN, MAX | SGN, MAX, MAX | SGN};
    logic [31:0] rss[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] rts[5] = '{32'd1, 32'd1, 32'd5, 32'd1, 32'd3};
    logic [31:0] exps[5] = '{32'd1, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'd3};
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      send(ops[i], 0, rss[i], rts[i], 32'h1234, 32'h5678, w);
      checks++;
      if ({out_valid, aluip_fin1, aluip_fin2, red_count} !== {1'b1, exps[i], 32'd0, 8'd0}) begin
        errors++;
        $display("FAIL minmax[%0d]: got v=%b f1=%h f2=%h cnt=%0d required v=1 f1=%h f2=0 cnt=0",
                 i, out_valid, aluip_fin1, aluip_fin2, red_count, exps[i]);
      end
    end
  endtask

  task automatic test_reduction;
    int w;
    out_ready = 1;
    send(RMAX, 0, 3, 9, 0, 0, w);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rmax_beat1: out_valid=%b required 0", out_valid); end
    send(RMAX, 0, 12, 4, 0, 0, w);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rmax_beat2: out_valid=%b required 0", out_valid); end
    send(RMAX, 1, 7, 7, 0, 0, w);
    checks++;
    if ({out_valid, aluip_fin1, aluip_fin2, red_count} !== {1'b1, 32'd12, 32'd0, 8'd3}) begin
      errors++; $display("FAIL rmax_last: got f1=%0d cnt=%0d v=%b required 12/3/1", aluip_fin1, red_count, out_valid);
    end
    send(RMAX, 1, 1, 2, 0, 0, w);
    checks++;
    if ({aluip_fin1, red_count} !== {32'd2, 8'd1}) begin
      errors++; $display("FAIL rmax_cleared: got f1=%0d cnt=%0d required 2/1", aluip_fin1, red_count);
    end
  endtask

  task automatic test_interleave;
    int w;
    out_ready = 1;
    send(RMIN, 0, 5, 8, 0, 0, w);
    send(PASS, 0, 0, 0, 32'hA, 32'hB, w);
    checks++;
    if ({out_valid, aluip_fin1, aluip_fin2, red_count} !== {1'b1, 32'hA, 32'hB, 8'd0}) begin
      errors++; $display("FAIL interleave_pass: got f1=%h f2=%h cnt=%0d required a/b/0", aluip_fin1, aluip_fin2, red_count);
    end
    send(RMIN, 1, 6, 2, 0, 0, w);
    checks++;
    if ({out_valid, aluip_fin1, red_count, red_discard} !== {1'b1, 32'd2, 8'd2, 1'b0}) begin
      errors++; $display("FAIL interleave_last: got f1=%0d cnt=%0d d=%b required 2/2/0", aluip_fin1, red_count, red_discard);
    end
    // Kind mismatch (min vs max): restart from the mismatching last beat.
    send(RMIN, 0, 5, 8, 0, 0, w);
    send(RMAX, 1, 6, 2, 0, 0, w);
    checks++;
    if ({out_valid, aluip_fin1, red_count, red_discard} !== {1'b1, 32'd6, 8'd1, 1'b1}) begin
      errors++; $display("FAIL mismatch_kind: got f1=%0d cnt=%0d d=%b required 6/1/1", aluip_fin1, red_count, red_discard);
    end
    @(negedge clk);
    checks++;
    if (red_discard !== 1'b0) begin errors++; $display("FAIL mismatch_pulse: red_discard=%b required 0", red_discard); end
    // Signedness mismatch on a non-last beat: pulse with no output.
    send(RMIN, 0, 5, 8, 0, 0, w);
    send(RMIN | SGN, 0, 32'hFFFFFFFE, 4, 0, 0, w);
    checks++;
    if ({out_valid, red_discard} !== 2'b01) begin
      errors++; $display("FAIL mismatch_sign: got v=%b d=%b required v=0 d=1", out_valid, red_discard);
    end
    send(RMIN | SGN, 1, 3, 7, 0, 0, w);
    checks++;
    if ({aluip_fin1, red_count, red_discard} !== {32'hFFFFFFFE, 8'd2, 1'b0}) begin
      errors++; $display("FAIL mismatch_restart: got f1=%h cnt=%0d d=%b required fffffffe/2/0", aluip_fin1, red_count, red_discard);
    end
  endtask

  task automatic test_back_to_back;
    int w;
    logic [31:0] a, b, e;
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = $urandom;
      e = (a < b) ? a : b;
      send(MIN, 0, a, b, 0, 0, w);
      checks++;
      if (w != 0 || out_valid !== 1'b1 || aluip_fin1 !== e) begin
        errors++; $display("FAIL back_to_back[%0d]: waited=%0d v=%b f1=%h required 0/1/%h", i, w, out_valid, aluip_fin1, e);
      end
    end
  endtask

  task automatic test_saturation;
    int w;
    out_ready = 1;
    for (int i = 0; i < 259; i++) send(RMAX, 0, i, 0, 0, 0, w);
    send(RMAX, 1, 259, 0, 0, 0, w);
    checks++;
    if ({aluip_fin1, red_count} !== {32'd259, 8'd255}) begin
      errors++; $display("FAIL saturation: got f1=%0d cnt=%0d required 259/255", aluip_fin1, red_count);
    end
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(3))
      0: return 32'($urandom_range(15));
      1: return 32'hFFFFFFF0 + 32'($urandom_range(15));
      2: return 32'h7FFFFFF8 + 32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random_backpressure;
    bit disc_pend, disc, rdy;
    exp_t e;
    exp_q.delete(); red_b.delete(); m_active = 0;
    disc_pend = 0;
    out_ready = 1; in_valid = 0;
    @(negedge clk);
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      checks++;
      if (red_discard !== disc_pend) begin
        errors++; $display("FAIL rand_discard[%0d]: got %b required %b", cyc, red_discard, disc_pend);
      end
      checks++;
      if (out_valid !== (exp_q.size() != 0)) begin
        errors++; $display("FAIL rand_valid[%0d]: got %b required %b", cyc, out_valid, exp_q.size() != 0);
      end
      out_ready = ($urandom_range(2) != 0);
      if (out_valid && out_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({aluip_fin1, aluip_fin2, red_count} !== e) begin
          errors++; $display("FAIL rand_data[%0d]: got %h/%h/%0d required %h/%h/%0d",
                             cyc, aluip_fin1, aluip_fin2, red_count, e.f1, e.f2, e.cnt);
        end
      end
      in_valid = ($urandom_range(3) != 0);
      op = {1'($urandom_range(1)), 3'($urandom_range(7))};
      if ($urandom_range(1) == 1) op[2:0] = 3'(3 + $urandom_range(1));
      red_last = ($urandom_range(3) == 0);
      rs_val = rand_val(); rt_val = rand_val(); aluip1 = $urandom; aluip2 = $urandom;
      rdy = !out_valid || out_ready;
      #1;
      checks++;
      if (in_ready !== rdy) begin errors++; $display("FAIL rand_ready[%0d]: got %b required %b", cyc, in_ready, rdy); end
      disc_pend = 0;
      if (in_valid && rdy) begin
        model_accept(op, red_last, rs_val, rt_val, aluip1, aluip2, disc);
        disc_pend = disc;
      end
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({out_valid, aluip_fin1, aluip_fin2, red_count} !== {1'b1, e}) begin
        errors++; $display("FAIL rand_tail: got v=%b %h/%h/%0d required %h/%h/%0d",
                           out_valid, aluip_fin1, aluip_fin2, red_count, e.f1, e.f2, e.cnt);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rand_empty: out_valid=%b required 0", out_valid); end
    // Close any reduction the random stream left open so later tests start idle.
    if (m_active) begin
      int w;
      send(m_max ? RMAX : RMIN, 1, 0, 0, 0, 0, w);
      red_b.delete(); m_active = 0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    int w;
    out_ready = 1;
    send(RMIN, 0, 10, 20, 0, 0, w);
    send(RMIN, 0, 3, 30, 0, 0, w);
    send(PASS, 0, 0, 0, 32'h77, 32'h88, w);
    rst_n = 0;
    in_valid = 1; op = RMIN; red_last = 1; rs_val = 1; rt_val = 1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, aluip_fin1, aluip_fin2, red_count, red_discard} !== 75'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got rdy=%b v=%b f1=%h f2=%h cnt=%0d d=%b required all 0",
               in_ready, out_valid, aluip_fin1, aluip_fin2, red_count, red_discard);
    end
    in_valid = 0;
    rst_n = 1;
    send(RMIN, 1, 4, 9, 0, 0, w);
    checks++;
    if ({out_valid, aluip_fin1, aluip_fin2, red_count, red_discard} !== {1'b1, 32'd4, 32'd0, 8'd1, 1'b0}) begin
      errors++; $display("FAIL reset_mid_restart: got f1=%0d cnt=%0d d=%b required 4/1/0", aluip_fin1, red_count, red_discard);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_signedness();
    test_reduction();
    test_interleave();
    test_back_to_back();
    test_saturation();
    test_random_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmov_select_stage.md
# cmov_select_stage

Registered, parametrised successor to the single-cycle conditional-move operand selector in the execute stage. Sits between operand fetch and the ALU inputs: per instruction it either passes the ALU operands through or replaces them with a signed/unsigned min/max of rs/rt. It adds a multi-beat reduction mode that accumulates a running min/max across several instructions. All traffic uses a valid/ready handshake with one output register stage.

## Interface
- WIDTH, 32, operand and result width
- CNT_W, 8, width of the reduction beat counter (saturating)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- op  in  4  op[3] = signed compare; op[2:0]: 0 PASS, 1 MIN, 2 MAX, 3 RMIN, 4 RMAX, 5-7 treated as PASS
- red_last  in  1  with RMIN/RMAX: final beat of the reduction
- rs_val, rt_val  in  WIDTH  compare operands
- aluip1, aluip2  in  WIDTH  ALU operands for PASS
- out_valid  out  1  output register holds a result
- out_ready  in  1  downstream accepts the result
- aluip_fin1, aluip_fin2  out  WIDTH  final ALU operands / result
- red_count  out  CNT_W  beats in the reduction just emitted; 0 for non-reduction results
- red_discard  out  1  one-cycle pulse: live accumulator was discarded

## Operation
- Accept when in_valid && in_ready. in_ready = !out_valid || out_ready. It is forced 0 while rst_n = 0.
- PASS: fin1 = aluip1, fin2 = aluip2.
- MIN/MAX: fin1 = min/max(rs_val, rt_val), fin2 = 0. The compare is signed when op[3] = 1 and unsigned otherwise. On a tie, rs_val is selected.
- State: acc (WIDTH), acc_active, acc_kind {min/max, signed}, acc_cnt (CNT_W).
- RMIN/RMAX beat computes b = min/max(rs_val, rt_val).
  - If !acc_active: acc = b, cnt = 1.
  - Otherwise: acc = min/max(acc, b) under acc_kind, cnt = cnt + 1, saturating at 2^CNT_W-1.
- Non-last reduction beats produce no output. out_valid is not set, and the beat is still consumed when in_ready = 1.
- red_last beat:
  - Outputs fin1 = final accumulated value, fin2 = 0, red_count = final cnt.
  - Clears acc_active, acc, and cnt.
  - A single-beat reduction (first beat is last) gives fin1 = b, red_count = 1.
- Kind mismatch: a reduction beat while acc_active whose kind (min/max or signedness) differs from acc_kind.
  - The accumulator is discarded and restarted from this beat.
  - red_discard pulses for one cycle.
- Interleaving: PASS/MIN/MAX beats during an active reduction are processed normally and leave acc/acc_kind/cnt untouched.
- red_last is ignored for non-reduction ops.

## Timing
- Latency 1: a result accepted at edge N is visible with out_valid = 1 after edge N.
- Output holds stable while out_valid && !out_ready.
- Throughput: 1 beat/cycle when out_ready is held 1.
- Simultaneous accept and drain (out_valid && out_ready && in_valid) loads the new result in the same edge with no bubble.
- Non-last reduction beats accepted while out_valid && !out_ready are blocked, because in_ready = 0.
- Reset (rst_n = 0 at an edge):
  - out_valid = 0, aluip_fin1/aluip_fin2 = 0, red_count = 0, red_discard = 0.
  - acc = 0, acc_active = 0, cnt = 0.
  - A reduction in progress is dropped silently, with no red_discard.
- red_discard is registered and asserted for exactly the cycle after the mismatching beat is accepted. It is independent of out_valid.
- red_count saturates; acc continues updating after saturation.

## Test plan
- Handshake basics:
  - PASS beat aluip1 = 0x11, aluip2 = 0x22 with out_ready = 1 -> next cycle out_valid = 1, fin1 = 0x11, fin2 = 0x22, red_count = 0.
  - Hold out_ready = 0 for 3 cycles -> outputs stable, in_ready = 0.
- Signedness:
  - MIN unsigned, rs = 0xFFFFFFFF, rt = 1 -> fin1 = 1.
  - MIN signed (op = 4'b1001), same operands -> fin1 = 0xFFFFFFFF.
  - MAX signed, rs = rt = 5 -> fin1 = 5, fin2 = 0.
- RMAX unsigned reduction over beats (3,9), (12,4), (7,7 with red_last):
  - No output on beats 1-2.
  - After the last beat, fin1 = 12, red_count = 3.
  - acc_active cleared afterwards.
- Interleave and mismatch:
  - RMIN beat (5,8), then PASS (0xA, 0xB) -> PASS result emitted, accumulator intact.
  - Then RMIN last (6,2) -> fin1 = 2, red_count = 2.
  - Repeat with an RMAX beat instead -> red_discard pulses one cycle, and the reduction restarts with count 1.
- Back-to-back MIN beats with out_ready = 1 every cycle -> one result per cycle, no bubbles.
- Randomised out_ready backpressure -> no beat lost or duplicated.
- Reset mid-reduction after 2 RMIN beats: rst_n = 0 for one edge, then an RMIN last beat (4,9) -> fin1 = 4, red_count = 1. All outputs read 0 during reset.
